// File: rtl/sobel_core_pipe_pkg.sv
// sobel_pkg: shared mode encoding, gradient width and window indexing for the Sobel core
package sobel_pkg;
  typedef enum logic [1:0] {SOBEL_BIN, SOBEL_MAG, SOBEL_GX, SOBEL_GY} sobel_mode_e;
  function automatic int grad_w(input int data_w);
    return data_w + 3;
  endfunction
  function automatic int win_idx(input int r, input int c, input int data_w);
    return (3 * r + c) * data_w;
  endfunction
endpackage

// File: rtl/sobel_core_pipe_if.sv
// sobel_core_pipe_if: window-in / pixel-out stream with valid/ready and end-of-line sideband
// slave  (core side): win_i, mode_i, last_i, in_valid_i, out_ready_i in; in_ready_o, pixel_o, last_o, out_valid_o out
// master (producer/consumer side): the mirror image
interface sobel_core_pipe_if #(parameter int DATA_W = 8, parameter int OUT_W = 8) ();
  logic [9*DATA_W-1:0] win_i;
  logic [1:0]          mode_i;
  logic                last_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [OUT_W-1:0]    pixel_o;
  logic                last_o;
  logic                out_valid_o;
  logic                out_ready_i;
  modport slave (input win_i, mode_i, last_i, in_valid_i, out_ready_i,
                 output in_ready_o, pixel_o, last_o, out_valid_o);
  modport master (output win_i, mode_i, last_i, in_valid_i, out_ready_i,
                  input in_ready_o, pixel_o, last_o, out_valid_o);
endinterface

// File: rtl/sobel_core_pipe_grad.sv
// sobel_grad: combinational 3x3 Sobel kernel producing signed gx/gy from a packed row-major window
// win_i: 9 unsigned pixels, (r,c) at [(3r+c)*DATA_W +: DATA_W]; gx_o/gy_o: signed DATA_W+3 gradients
module sobel_grad
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int G_W = grad_w(DATA_W)
) (
  input  logic [9*DATA_W-1:0]  win_i,
  output logic signed [G_W-1:0] gx_o,
  output logic signed [G_W-1:0] gy_o
);
  logic signed [G_W-1:0] p [3][3];
  for (genvar r = 0; r < 3; r++) begin : g_r
    for (genvar c = 0; c < 3; c++) begin : g_c
      assign p[r][c] = $signed({3'b000, win_i[win_idx(r, c, DATA_W) +: DATA_W]});
    end
  end
  assign gx_o = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
  assign gy_o = (p[0][0] + (p[0][1] <<< 1) + p[0][2]) - (p[2][0] + (p[2][1] <<< 1) + p[2][2]);
endmodule

// File: rtl/sobel_core_pipe.sv
// sobel_core_pipe: 3-stage pipelined Sobel edge core with back-pressure, threshold and edge counter
// clk/rst_n: clock, sync active-low reset; s: window/pixel stream (slave modport);
// thresh_i: BIN threshold, read at stage 3; clear_i: sync clear of edge_cnt_o; edge_cnt_o: saturating hit count
module sobel_core_pipe
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W = 8,
  parameter int CNT_W = 32,
  localparam int G_W = grad_w(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_core_pipe_if.slave   s,
  input  logic [G_W-1:0]     thresh_i,
  input  logic               clear_i,
  output logic [CNT_W-1:0]   edge_cnt_o
);
  localparam logic [G_W-1:0] OMAX = G_W'({OUT_W{1'b1}});
  logic                  stall;
  logic signed [G_W-1:0] gx_d, gy_d, gx_q, gy_q;
  logic                  v1_q, v2_q, v3_q, last1_q, last2_q, last3_q, hit_q;
  sobel_mode_e           mode1_q, mode2_q;
  logic [G_W-1:0]        ax, ay, m_d, m2_q;
  logic                  hit_d;
  logic [OUT_W-1:0]      pixel_d, pixel_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  sobel_grad #(.DATA_W(DATA_W)) u_grad (.win_i(s.win_i), .gx_o(gx_d), .gy_o(gy_d));
  // Whole pipe freezes while the output register holds an unaccepted pixel
  assign stall = v3_q && !s.out_ready_i;
  assign s.in_ready_o = rst_n && !stall;
  assign s.out_valid_o = v3_q;
  assign s.pixel_o = pixel_q;
  assign s.last_o = last3_q;
  assign edge_cnt_o = cnt_q;
  always_comb begin
    ax = gx_q[G_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay = gy_q[G_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    m_d = mode1_q == SOBEL_GX ? ax : mode1_q == SOBEL_GY ? ay : ax + ay;
    hit_d = m2_q > thresh_i;
    pixel_d = mode2_q == SOBEL_BIN ? {OUT_W{hit_d}} : (m2_q > OMAX ? '1 : m2_q[OUT_W-1:0]);
    cnt_d = clear_i ? '0 : (v3_q && s.out_ready_i && hit_q && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {v1_q, v2_q, v3_q, last1_q, last2_q, last3_q, hit_q} <= '0;
      gx_q <= '0;
      gy_q <= '0;
      m2_q <= '0;
      mode1_q <= SOBEL_BIN;
      mode2_q <= SOBEL_BIN;
      pixel_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!stall) begin
        v1_q <= s.in_valid_i;
        gx_q <= gx_d;
        gy_q <= gy_d;
        mode1_q <= sobel_mode_e'(s.mode_i);
        last1_q <= s.last_i;
        v2_q <= v1_q;
        m2_q <= m_d;
        mode2_q <= mode1_q;
        last2_q <= last1_q;
        v3_q <= v2_q;
        pixel_q <= pixel_d;
        last3_q <= last2_q;
        hit_q <= hit_d;
      end
    end
  end
endmodule
